axil_sram_param: RTL and testbench
==================================

AXIL_SRAM_PARAM -- requirements
Module: axil_sram_param

Interface
REQ-001 SHALL have parameter DATA_W, default 128, meaning data bus width in bits (a multiple of 8, from 32 to 256).
REQ-002 SHALL have parameter DEPTH_WORDS, default 4096, meaning the number of DATA_W-wide words (a power of two).
REQ-003 SHALL have parameter READ_LAT, default 1, meaning array read latency in cycles (1 or 2).
REQ-004 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-005 clk  in  1  clock; all logic on the rising edge.
REQ-006 n_rst  in  1  reset, asynchronous, active-low.
REQ-007 readAddr_addr  in  ADDR_W  read byte address; readAddr_valid in 1; readAddr_ready out 1.
REQ-008 readData_data  out  DATA_W  read word; readData_resp out 2 (OKAY=00, SLVERR=10); readData_valid out 1; readData_ready in 1.
REQ-009 writeAddr_addr  in  ADDR_W  write byte address; writeAddr_valid in 1; writeAddr_ready out 1.
REQ-010 writeData_data  in  DATA_W; writeData_strb in DATA_W/8 (byte enables); writeData_valid in 1; writeData_ready out 1.
REQ-011 writeResp_resp  out  2  write response; writeResp_valid out 1; writeResp_ready in 1.

Function
REQ-012 SHALL treat addresses as byte addresses; word index = addr / (DATA_W/8); low log2(DATA_W/8) bits ignored.
REQ-013 Read FSM SHALL have states RIDLE, RWAIT, RDATA; readAddr_ready=1 only in RIDLE.
REQ-014 Read handshake at edge N SHALL assert readData_valid from edge N+READ_LAT (RWAIT used only when READ_LAT=2).
REQ-015 readData_data/readData_resp SHALL hold stable while readData_valid=1 and readData_ready=0; RDATA->RIDLE on readData_ready.
REQ-016 Write FSM SHALL have states WIDLE, WAITWDATA, WAITWADDR, WRITE, WRESP; address and data accepted in either order or together.
REQ-017 writeAddr_ready SHALL be 1 in WIDLE/WAITWADDR only; writeData_ready SHALL be 1 in WIDLE/WAITWDATA only.
REQ-018 In WRITE the array SHALL update only bytes with strb=1 (lane i = bits 8i+7:8i); all other bytes unchanged.
REQ-019 writeResp_valid SHALL assert the cycle after WRITE and hold until writeResp_ready; no new AW/W accepted until then.
REQ-020 All-zero strobe SHALL write nothing and respond OKAY.
REQ-021 A read and a write to the same word in the same cycle SHALL return pre-write data (read-before-write).
REQ-022 Read and write channels SHALL operate independently and concurrently.

Reset
REQ-023 On n_rst low: both FSMs -> idle; readData_valid=0, writeResp_valid=0, readData_data=0, responses=00; in-flight transactions dropped.
REQ-024 Memory contents SHALL NOT be reset or cleared.

Configuration
REQ-025 Macro AXIL_SRAM_RANGE_CHK_EN defined: an address with word index >= DEPTH_WORDS SHALL suppress the write, return read data 0, and respond SLVERR.
REQ-026 Macro undefined: the word index SHALL wrap modulo DEPTH_WORDS; response always OKAY.

Structure
REQ-027 Shared package axil_pkg SHALL hold response constants (RESP_OKAY, RESP_SLVERR) and read/write FSM state encodings.
REQ-028 The storage array SHALL be sub-module sram_bytelane_array (byte-enable write port, read port with READ_LAT latency).

Verification
REQ-029 DATA_W=128: write 0x00112233_44556677_8899AABB_CCDDEEFF to 0x40 with strb=FFFF, read 0x40 -> same data, both resp=00.
REQ-030 Write 0xFF..FF to 0x40 with strb=0x000F, read back -> only bytes 3:0 = FF, others unchanged.
REQ-031 AW at cycle 0, W at cycle 3 -> single write; writeResp_valid rises cycle 5; readiness drops as per REQ-017.
REQ-032 READ_LAT=2, readData_ready held 0 for 4 cycles -> readData_valid at N+2, data stable, readAddr_ready=0 throughout.
REQ-033 With AXIL_SRAM_RANGE_CHK_EN, DEPTH_WORDS=16: write/read 0x100 -> SLVERR, read data 0, word 0 unchanged; without macro -> aliases word 0.
REQ-034 Assert n_rst during WRESP with writeResp_ready=0 -> writeResp_valid=0 immediately, FSM WIDLE, memory retains written data.

Source files
------------

// File: rtl/axil_pkg.sv
// axil_pkg: shared definitions for the AXI-Lite SRAM slice.
//   RESP_OKAY / RESP_SLVERR : 2-bit response codes for read data and write response
//   rd_state_e              : read-channel FSM states
//   wr_state_e              : write-channel FSM states
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    RIDLE = 2'd0,
    RWAIT = 2'd1,
    RDATA = 2'd2
  } rd_state_e;

  typedef enum logic [2:0] {
    WIDLE     = 3'd0,
    WAITWDATA = 3'd1,
    WAITWADDR = 3'd2,
    WRITE     = 3'd3,
    WRESP     = 3'd4
  } wr_state_e;

endpackage

// File: rtl/axil_sram_param_if.sv
// axil_sram_param_if: AXI-Lite style bus bundle for axil_sram_param.
//   readAddr_*  : read address channel  (addr, valid / ready)
//   readData_*  : read data channel     (data, resp, valid / ready)
//   writeAddr_* : write address channel (addr, valid / ready)
//   writeData_* : write data channel    (data, strb, valid / ready)
//   writeResp_* : write response channel(resp, valid / ready)
// Modports: master (bus initiator), slave (the SRAM).
interface axil_sram_param_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 128
);
  logic [ADDR_W-1:0]   readAddr_addr;
  logic                readAddr_valid;
  logic                readAddr_ready;
  logic [DATA_W-1:0]   readData_data;
  logic [1:0]          readData_resp;
  logic                readData_valid;
  logic                readData_ready;
  logic [ADDR_W-1:0]   writeAddr_addr;
  logic                writeAddr_valid;
  logic                writeAddr_ready;
  logic [DATA_W-1:0]   writeData_data;
  logic [DATA_W/8-1:0] writeData_strb;
  logic                writeData_valid;
  logic                writeData_ready;
  logic [1:0]          writeResp_resp;
  logic                writeResp_valid;
  logic                writeResp_ready;

  modport master (
    output readAddr_addr, readAddr_valid, input readAddr_ready,
    input  readData_data, readData_resp, readData_valid, output readData_ready,
    output writeAddr_addr, writeAddr_valid, input writeAddr_ready,
    output writeData_data, writeData_strb, writeData_valid, input writeData_ready,
    input  writeResp_resp, writeResp_valid, output writeResp_ready
  );

  modport slave (
    input  readAddr_addr, readAddr_valid, output readAddr_ready,
    output readData_data, readData_resp, readData_valid, input readData_ready,
    input  writeAddr_addr, writeAddr_valid, output writeAddr_ready,
    input  writeData_data, writeData_strb, writeData_valid, output writeData_ready,
    output writeResp_resp, writeResp_valid, input writeResp_ready
  );
endinterface

// File: rtl/sram_bytelane_array.sv
// sram_bytelane_array: DEPTH_WORDS x DATA_W storage with a byte-enable write
// port and a registered read port of READ_LAT (1 or 2) cycles.
//   clk, n_rst          : clock, async active-low reset (read registers only;
//                         the array itself is never cleared)
//   rd_en_i, rd_idx_i   : read request and word index
//   rd_data_o           : read word, valid READ_LAT edges after rd_en_i
//   we_i, wr_idx_i      : write enable and word index
//   wr_strb_i, wr_data_i: byte enables and write word
module sram_bytelane_array #(
  parameter int unsigned DATA_W      = 128,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned READ_LAT    = 1,
  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS),
  localparam int unsigned STRB_W     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              rd_en_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [STRB_W-1:0] wr_strb_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rd1_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (wr_strb_i[i]) mem_q[wr_idx_i][8*i +: 8] <= wr_data_i[8*i +: 8];
      end
    end
  end

  // Read samples the array before the same-edge write lands (read-before-write).
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)       rd1_q <= '0;
    else if (rd_en_i) rd1_q <= mem_q[rd_idx_i];
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] rd2_q;
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) rd2_q <= '0;
        else        rd2_q <= rd1_q;
      end
      assign rd_data_o = rd2_q;
    end else begin : g_lat1
      assign rd_data_o = rd1_q;
    end
  endgenerate

endmodule

// File: rtl/axil_sram_param.sv
// axil_sram_param: AXI-Lite slave SRAM with independent read and write channels.
//   clk   : clock, rising edge
//   n_rst : asynchronous active-low reset (FSMs and responses; memory kept)
//   bus   : axil_sram_param_if.slave (read/write address, data, response channels)
// Optional build macro AXIL_SRAM_RANGE_CHK_EN: word indices >= DEPTH_WORDS are
// rejected with SLVERR (write suppressed, read data 0). Without it the index
// wraps modulo DEPTH_WORDS and every response is OKAY.
module axil_sram_param
  import axil_pkg::*;
#(
  parameter int unsigned DATA_W      = 128,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned READ_LAT    = 1,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic             clk,
  input  logic             n_rst,
  axil_sram_param_if.slave bus
);

  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned IDX_LSB = $clog2(STRB_W);
  localparam int unsigned IDX_W   = $clog2(DEPTH_WORDS);

  logic [IDX_W-1:0] ar_idx, aw_idx;
  logic             ar_oob, aw_oob;
  logic             unused_addr_bits;

  assign ar_idx = bus.readAddr_addr[IDX_LSB +: IDX_W];
  assign aw_idx = bus.writeAddr_addr[IDX_LSB +: IDX_W];
  assign unused_addr_bits = ^{bus.readAddr_addr, bus.writeAddr_addr};

`ifdef AXIL_SRAM_RANGE_CHK_EN
  assign ar_oob = |bus.readAddr_addr[ADDR_W-1:IDX_LSB+IDX_W];
  assign aw_oob = |bus.writeAddr_addr[ADDR_W-1:IDX_LSB+IDX_W];
`else
  assign ar_oob = 1'b0;
  assign aw_oob = 1'b0;
`endif

  // ---------------- read channel ----------------
  rd_state_e         rd_state_q, rd_state_d;
  logic              rd_hs;
  logic              rd_oob_q;
  logic [1:0]        rd_resp_q;
  logic [DATA_W-1:0] sram_rdata;

  assign rd_hs = bus.readAddr_valid && (rd_state_q == RIDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) rd_state_q <= RIDLE;
    else        rd_state_q <= rd_state_d;
  end

  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      RIDLE:   if (bus.readAddr_valid) rd_state_d = (READ_LAT == 2) ? RWAIT : RDATA;
      RWAIT:   rd_state_d = RDATA;
      RDATA:   if (bus.readData_ready) rd_state_d = RIDLE;
      default: rd_state_d = RIDLE;
    endcase
  end

  always_comb begin
    bus.readAddr_ready = (rd_state_q == RIDLE);
    bus.readData_valid = (rd_state_q == RDATA);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_oob_q  <= 1'b0;
      rd_resp_q <= RESP_OKAY;
    end else if (rd_hs) begin
      rd_oob_q  <= ar_oob;
      rd_resp_q <= ar_oob ? RESP_SLVERR : RESP_OKAY;
    end
  end

  assign bus.readData_data = rd_oob_q ? '0 : sram_rdata;
  assign bus.readData_resp = rd_resp_q;

  // ---------------- write channel ----------------
  wr_state_e         wr_state_q, wr_state_d;
  logic              aw_rdy, w_rdy, mem_we;
  logic [IDX_W-1:0]  aw_idx_q;
  logic              aw_oob_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [1:0]        wr_resp_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) wr_state_q <= WIDLE;
    else        wr_state_q <= wr_state_d;
  end

  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      WIDLE: begin
        case ({bus.writeAddr_valid, bus.writeData_valid})
          2'b11:   wr_state_d = WRITE;
          2'b10:   wr_state_d = WAITWDATA;
          2'b01:   wr_state_d = WAITWADDR;
          default: wr_state_d = WIDLE;
        endcase
      end
      WAITWDATA: if (bus.writeData_valid) wr_state_d = WRITE;
      WAITWADDR: if (bus.writeAddr_valid) wr_state_d = WRITE;
      WRITE:     wr_state_d = WRESP;
      WRESP:     if (bus.writeResp_ready) wr_state_d = WIDLE;
      default:   wr_state_d = WIDLE;
    endcase
  end

  always_comb begin
    aw_rdy = (wr_state_q == WIDLE) || (wr_state_q == WAITWADDR);
    w_rdy  = (wr_state_q == WIDLE) || (wr_state_q == WAITWDATA);
    mem_we = (wr_state_q == WRITE) && !aw_oob_q;
    bus.writeAddr_ready = aw_rdy;
    bus.writeData_ready = w_rdy;
    bus.writeResp_valid = (wr_state_q == WRESP);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      aw_idx_q  <= '0;
      aw_oob_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wr_resp_q <= RESP_OKAY;
    end else begin
      if (aw_rdy && bus.writeAddr_valid) begin
        aw_idx_q <= aw_idx;
        aw_oob_q <= aw_oob;
      end
      if (w_rdy && bus.writeData_valid) begin
        wdata_q <= bus.writeData_data;
        wstrb_q <= bus.writeData_strb;
      end
      if (wr_state_q == WRITE) wr_resp_q <= aw_oob_q ? RESP_SLVERR : RESP_OKAY;
    end
  end

  assign bus.writeResp_resp = wr_resp_q;

  sram_bytelane_array #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .READ_LAT    (READ_LAT)
  ) u_array (
    .clk       (clk),
    .n_rst     (n_rst),
    .rd_en_i   (rd_hs),
    .rd_idx_i  (ar_idx),
    .rd_data_o (sram_rdata),
    .we_i      (mem_we),
    .wr_idx_i  (aw_idx_q),
    .wr_strb_i (wstrb_q),
    .wr_data_i (wdata_q)
  );

endmodule

// File: tb/tb_axil_sram_param.sv
// tb_axil_sram_param: directed scoreboard bench for axil_sram_param
// (DATA_W=128, DEPTH_WORDS=16, READ_LAT=2). Expected responses are queued when
// a transaction is issued; a negedge monitor pops and compares on each handshake.
module tb_axil_sram_param;
  import axil_pkg::*;

  localparam int unsigned DATA_W      = 128;
  localparam int unsigned DEPTH_WORDS = 16;
  localparam int unsigned READ_LAT    = 2;
  localparam int unsigned ADDR_W      = 32;

  localparam logic [127:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] D2 = 128'h00112233_44556677_8899AABB_FFFFFFFF;
  localparam logic [127:0] D3 = 128'h00000000_44556677_8899AABB_FFFFFFFF;
  localparam logic [127:0] D4 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] D5 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] D6 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] DA = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5;
  localparam logic [127:0] DB = 128'h5A5A5A5A_5A5A5A5A_5A5A5A5A_5A5A5A5A;
  localparam logic [127:0] DC = 128'hC0C0C0C0_12345678_C0C0C0C0_87654321;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  axil_sram_param_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axil_sram_param #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .READ_LAT    (READ_LAT),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [DATA_W+1:0] rexp_q[$];
  logic [1:0]        wexp_q[$];
  logic [DATA_W+1:0] rcur;
  logic [1:0]        wcur;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (n_rst && bus.readData_valid && bus.readData_ready) begin
      check("rd_expected", DATA_W'(rexp_q.size() != 0), DATA_W'(1'b1));
      if (rexp_q.size() != 0) begin
        rcur = rexp_q.pop_front();
        check("rd_data", bus.readData_data, rcur[DATA_W-1:0]);
        check("rd_resp", DATA_W'(bus.readData_resp), DATA_W'(rcur[DATA_W+1:DATA_W]));
      end
    end
    if (n_rst && bus.writeResp_valid && bus.writeResp_ready) begin
      check("wr_expected", DATA_W'(wexp_q.size() != 0), DATA_W'(1'b1));
      if (wexp_q.size() != 0) begin
        wcur = wexp_q.pop_front();
        check("wr_resp", DATA_W'(bus.writeResp_resp), DATA_W'(wcur));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rd_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.readData_valid && bus.readData_ready;
    end
    check(name, DATA_W'(seen), DATA_W'(1'b1));
    step();
  endtask

  task automatic wait_wr_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.writeResp_valid && bus.writeResp_ready;
    end
    check(name, DATA_W'(seen), DATA_W'(1'b1));
    step();
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [DATA_W/8-1:0] s, input logic [1:0] r);
    bit seen;
    wexp_q.push_back(r);
    bus.writeAddr_addr  = a;
    bus.writeData_data  = d;
    bus.writeData_strb  = s;
    bus.writeAddr_valid = 1'b1;
    bus.writeData_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.writeAddr_ready && bus.writeData_ready;
    end
    check("aw_w_accept", DATA_W'(seen), DATA_W'(1'b1));
    step();
    bus.writeAddr_valid = 1'b0;
    bus.writeData_valid = 1'b0;
    wait_wr_done("wr_resp_timeout");
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input logic [1:0] r);
    bit seen;
    rexp_q.push_back({r, d});
    bus.readAddr_addr  = a;
    bus.readAddr_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.readAddr_ready;
    end
    check("ar_accept", DATA_W'(seen), DATA_W'(1'b1));
    step();
    bus.readAddr_valid = 1'b0;
    wait_rd_done("rd_data_timeout");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    bus.readAddr_addr   = '0;
    bus.readAddr_valid  = 1'b0;
    bus.readData_ready  = 1'b1;
    bus.writeAddr_addr  = '0;
    bus.writeAddr_valid = 1'b0;
    bus.writeData_data  = '0;
    bus.writeData_strb  = '0;
    bus.writeData_valid = 1'b0;
    bus.writeResp_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rvalid", DATA_W'(bus.readData_valid), '0);
    check("rst_bvalid", DATA_W'(bus.writeResp_valid), '0);
    check("rst_rdata", bus.readData_data, '0);
    check("rst_rresp", DATA_W'(bus.readData_resp), '0);
    check("rst_bresp", DATA_W'(bus.writeResp_resp), '0);
    check("rst_arready", DATA_W'(bus.readAddr_ready), DATA_W'(1'b1));
    check("rst_awready", DATA_W'(bus.writeAddr_ready), DATA_W'(1'b1));
    check("rst_wready", DATA_W'(bus.writeData_ready), DATA_W'(1'b1));
    n_rst = 1'b1;
    step();

    // Full write / read back, low address bits ignored.
    do_write(32'h40, D1, 16'hFFFF, RESP_OKAY);
    do_read(32'h40, D1, RESP_OKAY);
    do_read(32'h4C, D1, RESP_OKAY);

    // Partial strobes and all-zero strobe.
    do_write(32'h40, '1, 16'h000F, RESP_OKAY);
    do_read(32'h40, D2, RESP_OKAY);
    do_write(32'h48, '0, 16'hF000, RESP_OKAY);
    do_read(32'h40, D3, RESP_OKAY);
    do_write(32'h40, '0, 16'h0000, RESP_OKAY);
    do_read(32'h40, D3, RESP_OKAY);

    // AW in cycle 0, W in cycle 3, response visible in cycle 5.
    bus.writeResp_ready = 1'b0;
    bus.writeAddr_addr  = 32'h80;
    bus.writeAddr_valid = 1'b1;
    @(negedge clk);
    check("split_c0_awready", DATA_W'(bus.writeAddr_ready), DATA_W'(1'b1));
    step();
    bus.writeAddr_valid = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      check("split_wait_awready", DATA_W'(bus.writeAddr_ready), '0);
      check("split_wait_wready", DATA_W'(bus.writeData_ready), DATA_W'(1'b1));
      check("split_wait_bvalid", DATA_W'(bus.writeResp_valid), '0);
      step();
    end
    wexp_q.push_back(RESP_OKAY);
    bus.writeData_data  = D4;
    bus.writeData_strb  = 16'hFFFF;
    bus.writeData_valid = 1'b1;
    @(negedge clk);
    check("split_c3_wready", DATA_W'(bus.writeData_ready), DATA_W'(1'b1));
    step();
    bus.writeData_valid = 1'b0;
    @(negedge clk);
    check("split_c4_awready", DATA_W'(bus.writeAddr_ready), '0);
    check("split_c4_wready", DATA_W'(bus.writeData_ready), '0);
    check("split_c4_bvalid", DATA_W'(bus.writeResp_valid), '0);
    step();
    @(negedge clk);
    check("split_c5_bvalid", DATA_W'(bus.writeResp_valid), DATA_W'(1'b1));
    step();
    @(negedge clk);
    check("split_hold_bvalid", DATA_W'(bus.writeResp_valid), DATA_W'(1'b1));
    check("split_hold_awready", DATA_W'(bus.writeAddr_ready), '0);
    check("split_hold_wready", DATA_W'(bus.writeData_ready), '0);
    step();
    bus.writeResp_ready = 1'b1;
    wait_wr_done("split_resp_timeout");
    do_read(32'h80, D4, RESP_OKAY);

    // Read landing on the same edge as the write commit sees old data.
    wexp_q.push_back(RESP_OKAY);
    bus.writeAddr_addr  = 32'h80;
    bus.writeData_data  = D5;
    bus.writeData_strb  = 16'hFFFF;
    bus.writeAddr_valid = 1'b1;
    bus.writeData_valid = 1'b1;
    @(negedge clk);
    step();
    bus.writeAddr_valid = 1'b0;
    bus.writeData_valid = 1'b0;
    rexp_q.push_back({RESP_OKAY, D4});
    bus.readAddr_addr  = 32'h80;
    bus.readAddr_valid = 1'b1;
    @(negedge clk);
    check("rbw_arready", DATA_W'(bus.readAddr_ready), DATA_W'(1'b1));
    step();
    bus.readAddr_valid = 1'b0;
    wait_rd_done("rbw_rd_timeout");
    check("rbw_wr_done", DATA_W'(wexp_q.size()), '0);
    do_read(32'h80, D5, RESP_OKAY);

    // Read latency 2 with readData_ready stalled for 4 cycles.
    bus.readData_ready = 1'b0;
    rexp_q.push_back({RESP_OKAY, D5});
    bus.readAddr_addr  = 32'h80;
    bus.readAddr_valid = 1'b1;
    @(negedge clk);
    check("stall_arready_n", DATA_W'(bus.readAddr_ready), DATA_W'(1'b1));
    step();
    bus.readAddr_valid = 1'b0;
    @(negedge clk);
    check("stall_rvalid_n1", DATA_W'(bus.readData_valid), '0);
    check("stall_arready_n1", DATA_W'(bus.readAddr_ready), '0);
    step();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stall_rvalid", DATA_W'(bus.readData_valid), DATA_W'(1'b1));
      check("stall_arready", DATA_W'(bus.readAddr_ready), '0);
      check("stall_rdata", bus.readData_data, D5);
      step();
    end
    bus.readData_ready = 1'b1;
    wait_rd_done("stall_rd_timeout");

    // Last in-range word.
    do_write(32'hF0, D6, 16'hFFFF, RESP_OKAY);
    do_read(32'hF0, D6, RESP_OKAY);

    // Word index 16 (one past the end).
    do_write(32'h00, DA, 16'hFFFF, RESP_OKAY);
`ifdef AXIL_SRAM_RANGE_CHK_EN
    do_write(32'h100, DB, 16'hFFFF, RESP_SLVERR);
    do_read(32'h100, '0, RESP_SLVERR);
    do_read(32'h00, DA, RESP_OKAY);
`else
    do_write(32'h100, DB, 16'hFFFF, RESP_OKAY);
    do_read(32'h100, DB, RESP_OKAY);
    do_read(32'h00, DB, RESP_OKAY);
`endif

    // Reset while a write response is pending.
    bus.writeResp_ready = 1'b0;
    bus.writeAddr_addr  = 32'hC0;
    bus.writeData_data  = DC;
    bus.writeData_strb  = 16'hFFFF;
    bus.writeAddr_valid = 1'b1;
    bus.writeData_valid = 1'b1;
    @(negedge clk);
    step();
    bus.writeAddr_valid = 1'b0;
    bus.writeData_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.writeResp_valid;
    end
    check("rstw_bvalid_before", DATA_W'(seen), DATA_W'(1'b1));
    n_rst = 1'b0;
    #1;
    check("rstw_bvalid_now", DATA_W'(bus.writeResp_valid), '0);
    check("rstw_awready", DATA_W'(bus.writeAddr_ready), DATA_W'(1'b1));
    check("rstw_wready", DATA_W'(bus.writeData_ready), DATA_W'(1'b1));
    check("rstw_bresp", DATA_W'(bus.writeResp_resp), '0);
    step();
    n_rst = 1'b1;
    bus.writeResp_ready = 1'b1;
    step();
    do_read(32'hC0, DC, RESP_OKAY);
    do_read(32'h40, D3, RESP_OKAY);

    check("rd_queue_drained", DATA_W'(rexp_q.size()), '0);
    check("wr_queue_drained", DATA_W'(wexp_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
